alu_reg: RTL and testbench
==========================

Name: alu_reg

Overview:
- 32-bit registered integer ALU for the RV32I datapath, placed in the execute stage.
- Applies one of 16 operations, selected by the 4-bit `control` input, to operands `d1` and `d2`.
- Registers the result and a zero flag on the rising clock edge, giving a fixed one-cycle latency.
- Used for arithmetic, logic, shifts, set-less-than, branch comparisons and LUI pass-through.

Parameters:
- WIDTH, 32, datapath width of d1/d2/result. Only 32 is supported; the shift amount is always d2[4:0].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- d1  input  32  operand A (rs1/PC)
- d2  input  32  operand B (rs2/immediate)
- control  input  4  operation select
- result  output  32  registered operation result
- zero  output  1  registered flag, 1 when result == 0

Behaviour:
- Interface (already decided): one clock, `clk`; reset `rst` is asynchronous and active-high.
- Reset: while rst=1, result=32'h0 and zero=1, immediately and regardless of clk. On deassertion, the first rising edge captures normal operation.
- Latency: the operation on d1/d2/control sampled at rising edge N appears on result/zero after edge N. Back-to-back operations every cycle; no stall or handshake.
- zero is computed from the new result value, in the same register stage as result.
- Shift amount for all shifts = d2[4:0]; d2[31:5] is ignored.
- All arithmetic is modulo 2^32; there are no overflow or carry outputs.
- Comparison ops return 32'h1 when true, else 32'h0.
- control encoding:
  - 0000 ADD: d1+d2
  - 0001 SUB: d1-d2
  - 0010 SLL: d1 << shamt
  - 0011 SLT: signed d1<d2
  - 0100 SLTU: unsigned d1<d2
  - 0101 XOR
  - 0110 SRL: logical right shift
  - 0111 SRA: arithmetic right shift, sign-filled from d1[31]
  - 1000 OR
  - 1001 AND
  - 1010 PASSB: result=d2 (LUI)
  - 1011 EQ: d1==d2
  - 1100 NE: d1!=d2
  - 1101 GE: signed d1>=d2
  - 1110 GEU: unsigned d1>=d2
  - 1111 reserved: result=32'h0
- control containing X/Z bits (simulation): result=32'h0, zero=1; X must not propagate into the registers.
- Reset asserted mid-stream: the in-flight result is discarded. No memory of prior operations after reset.
- Shift by 0 returns d1 unchanged for SLL/SRL/SRA.
- The combinational datapath must settle within one clock period. No internal state other than the result/zero registers.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with prior result 0x11111111 -> result=0x00000000 and zero=1 immediately; they hold until the first edge after release.
- Sweep, d1=0x10101010, d2=0x01010101, control 0000..1111, one op per cycle. Each value appears one cycle after it is applied:
  - 0000 -> 0x11111111
  - 0001 -> 0x0F0F0F0F
  - 0010 -> 0x20202020
  - 0011 -> 0
  - 0100 -> 0
  - 0101 -> 0x11111111
  - 0110 -> 0x08080808
  - 0111 -> 0x08080808
  - 1000 -> 0x11111111
  - 1001 -> 0x00000000 with zero=1
  - 1010 -> 0x01010101
  - 1011 -> 0
  - 1100 -> 1
  - 1101 -> 1
  - 1110 -> 1
  - 1111 -> 0
- Signed vs unsigned, d1=0xFFFFFFFF, d2=0x00000001:
  - SLT -> 1; SLTU -> 0
  - GE -> 0; GEU -> 1
  - ADD -> 0x00000000 (wrap), zero=1
- Shifts, d1=0x80000000, d2=0xFFFFFFE4 (shamt=4):
  - SRA -> 0xF8000000
  - SRL -> 0x08000000
  - SLL -> 0x00000000
  - shamt=0 (d2=0x20) -> all three return 0x80000000
- Equality, d1=d2=0xDEADBEEF:
  - EQ -> 1, zero=0
  - NE -> 0, zero=1
  - SUB -> 0, zero=1
- X control: control=4'bXXXX for one cycle -> result=0, zero=1, no X on outputs.

Source files
------------

// File: rtl/alu_reg.sv
// Registered 32-bit RV32I execute-stage ALU: one operation per cycle, result and
// zero flag appear one clock after the operands and control are sampled.
module alu_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [3:0]       control,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_SLL   = 4'b0010;
   localparam logic [3:0] OP_SLT   = 4'b0011;
   localparam logic [3:0] OP_SLTU  = 4'b0100;
   localparam logic [3:0] OP_XOR   = 4'b0101;
   localparam logic [3:0] OP_SRL   = 4'b0110;
   localparam logic [3:0] OP_SRA   = 4'b0111;
   localparam logic [3:0] OP_OR    = 4'b1000;
   localparam logic [3:0] OP_AND   = 4'b1001;
   localparam logic [3:0] OP_PASSB = 4'b1010;
   localparam logic [3:0] OP_EQ    = 4'b1011;
   localparam logic [3:0] OP_NE    = 4'b1100;
   localparam logic [3:0] OP_GE    = 4'b1101;
   localparam logic [3:0] OP_GEU   = 4'b1110;

   logic [4:0]       shamt;
   logic             lt_s;
   logic             lt_u;
   logic             eq;
   logic [WIDTH-1:0] next_result;

   assign shamt = d2[4:0];
   assign lt_s  = $signed(d1) < $signed(d2);
   assign lt_u  = d1 < d2;
   assign eq    = d1 == d2;

   // Reserved codes and control with X/Z bits both fall into the default,
   // so nothing unknown can reach the registers.
   always_comb begin
      next_result = '0;
      case (control)
         OP_ADD:   next_result = d1 + d2;
         OP_SUB:   next_result = d1 - d2;
         OP_SLL:   next_result = d1 << shamt;
         OP_SLT:   next_result = {{(WIDTH-1){1'b0}}, lt_s};
         OP_SLTU:  next_result = {{(WIDTH-1){1'b0}}, lt_u};
         OP_XOR:   next_result = d1 ^ d2;
         OP_SRL:   next_result = d1 >> shamt;
         OP_SRA:   next_result = $unsigned($signed(d1) >>> shamt);
         OP_OR:    next_result = d1 | d2;
         OP_AND:   next_result = d1 & d2;
         OP_PASSB: next_result = d2;
         OP_EQ:    next_result = {{(WIDTH-1){1'b0}}, eq};
         OP_NE:    next_result = {{(WIDTH-1){1'b0}}, ~eq};
         OP_GE:    next_result = {{(WIDTH-1){1'b0}}, ~lt_s};
         OP_GEU:   next_result = {{(WIDTH-1){1'b0}}, ~lt_u};
         default:  next_result = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         zero   <= 1'b1;
      end else begin
         result <= next_result;
         zero   <= (next_result == '0);
      end
   end

endmodule

// File: tb/tb_alu_reg.sv
// Bench for alu_reg: directed sweeps pinned to hand-computed values plus random
// operations, all checked against an arithmetic model one cycle after issue.
module tb_alu_reg;

   logic        clk;
   logic        rst;
   logic [31:0] d1;
   logic [31:0] d2;
   logic [3:0]  control;
   logic [31:0] result;
   logic        zero;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_q[$];
   logic [31:0] lit_q[$];
   bit          has_lit_q[$];

   alu_reg #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .d1(d1), .d2(d2),
      .control(control), .result(result), .zero(zero)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model written from the operation definitions.
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
      int unsigned sh;
      longint ua, ub;
      int sa, sb;
      logic [31:0] r;
      sh = b % 32;
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      sa = int'(a);
      sb = int'(b);
      case (c)
         4'd0:  r = 32'(ua + ub);
         4'd1:  r = 32'(ua - ub);
         4'd2:  r = 32'(ua * (64'd1 << sh));
         4'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
         4'd4:  r = (ua < ub) ? 32'd1 : 32'd0;
         4'd5:  r = a ^ b;
         4'd6:  r = 32'(ua / (64'd1 << sh));
         4'd7: begin
            r = a;
            for (int i = 0; i < int'(sh); i++) r = {a[31], r[31:1]};
         end
         4'd8:  r = a | b;
         4'd9:  r = a & b;
         4'd10: r = b;
         4'd11: r = (ua == ub) ? 32'd1 : 32'd0;
         4'd12: r = (ua != ub) ? 32'd1 : 32'd0;
         4'd13: r = (sa >= sb) ? 32'd1 : 32'd0;
         4'd14: r = (ua >= ub) ? 32'd1 : 32'd0;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // driver
   task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                     input bit hl, input logic [31:0] lv);
      @(negedge clk);
      d1 = a;
      d2 = b;
      control = c;
      exp_q.push_back(model(a, b, c));
      lit_q.push_back(lv);
      has_lit_q.push_back(hl);
   endtask

   // scoreboard compare: every issued op is checked just after the next rising edge
   always @(posedge clk) begin
      logic [31:0] e, l;
      bit h;
      #1;
      if (!rst && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         l = lit_q.pop_front();
         h = has_lit_q.pop_front();
         chk("result_vs_model", result, e);
         chk("zero_vs_model", {31'b0, zero}, {31'b0, e == 32'd0});
         if (h) begin
            chk("result_vs_literal", result, l);
            chk("zero_vs_literal", {31'b0, zero}, {31'b0, l == 32'd0});
         end
      end
   end

   logic [31:0] sweep_exp[16] = '{32'h11111111, 32'h0F0F0F0F, 32'h20202020, 32'h0,
                                  32'h0, 32'h11111111, 32'h08080808, 32'h08080808,
                                  32'h11111111, 32'h0, 32'h01010101, 32'h0,
                                  32'h1, 32'h1, 32'h1, 32'h0};
   logic [31:0] corner[6] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                              32'h1, 32'h1F};

   initial begin
      rst = 1'b1;
      d1 = '0;
      d2 = '0;
      control = '0;
      #3;
      chk("reset_result", result, 32'h0);
      chk("reset_zero", {31'b0, zero}, 32'h1);
      @(negedge clk);
      rst = 1'b0;

      // full sweep
      for (int i = 0; i < 16; i++) op(32'h10101010, 32'h01010101, 4'(i), 1'b1, sweep_exp[i]);

      // prior result 0x11111111, then async reset mid-cycle with an op in flight
      op(32'h10101010, 32'h01010101, 4'd0, 1'b1, 32'h11111111);
      @(posedge clk);
      #2;
      d1 = 32'h5; d2 = 32'h3; control = 4'd1;
      rst = 1'b1;
      exp_q.delete(); lit_q.delete(); has_lit_q.delete();
      #1;
      chk("async_reset_result", result, 32'h0);
      chk("async_reset_zero", {31'b0, zero}, 32'h1);
      repeat (2) begin
         @(posedge clk); #1;
         chk("reset_hold_result", result, 32'h0);
         chk("reset_hold_zero", {31'b0, zero}, 32'h1);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("release_hold_result", result, 32'h0);

      // signed vs unsigned
      op(32'hFFFFFFFF, 32'h1, 4'd3,  1'b1, 32'h1);
      op(32'hFFFFFFFF, 32'h1, 4'd4,  1'b1, 32'h0);
      op(32'hFFFFFFFF, 32'h1, 4'd13, 1'b1, 32'h0);
      op(32'hFFFFFFFF, 32'h1, 4'd14, 1'b1, 32'h1);
      op(32'hFFFFFFFF, 32'h1, 4'd0,  1'b1, 32'h0);

      // shifts, upper d2 bits ignored
      op(32'h80000000, 32'hFFFFFFE4, 4'd7, 1'b1, 32'hF8000000);
      op(32'h80000000, 32'hFFFFFFE4, 4'd6, 1'b1, 32'h08000000);
      op(32'h80000000, 32'hFFFFFFE4, 4'd2, 1'b1, 32'h00000000);
      op(32'h80000000, 32'h20, 4'd7, 1'b1, 32'h80000000);
      op(32'h80000000, 32'h20, 4'd6, 1'b1, 32'h80000000);
      op(32'h80000000, 32'h20, 4'd2, 1'b1, 32'h80000000);
      op(32'h80000001, 32'h1F, 4'd7, 1'b1, 32'hFFFFFFFF);

      // equality
      op(32'hDEADBEEF, 32'hDEADBEEF, 4'd11, 1'b1, 32'h1);
      op(32'hDEADBEEF, 32'hDEADBEEF, 4'd12, 1'b1, 32'h0);
      op(32'hDEADBEEF, 32'hDEADBEEF, 4'd1,  1'b1, 32'h0);

      // unknown control
      op(32'h0, 32'h0, 4'bxxxx, 1'b1, 32'h0);
      @(posedge clk); #1;
      chk("x_ctrl_known", {31'b0, ^{result, zero} === 1'bx}, 32'h0);

      // random stimulus, mixing corner operands
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a, b;
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         if ($urandom_range(0, 7) == 0) b = a;
         op(a, b, 4'($urandom_range(0, 15)), 1'b0, 32'h0);
      end

      repeat (2) @(posedge clk);
      #2;
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
